event_readout_sequencer: RTL and testbench
==========================================

Name: event_readout_sequencer

Overview:
- Controls one drift-tube event from trigger to clear: opens the acquisition window, drives the global tube time counter, scans all tube channels into the readout FIFO, then clears the tube front-ends.
- Sits between the scintillator coincidence input, the tube time-capture channels and the 16x1024 readout FIFO on the clk100 domain.
- Replaces free-running cycle-count decoding with an explicit FSM that has FIFO backpressure and overflow drop handling.

Parameters:
- N_CH, 32, number of tube channels scanned per event (power of 2, max 32).
- ACQ_CYCLES, 256, acquisition window length in clk100 cycles.
- CLR_CYCLES, 11, tube_clr pulse length in cycles.
- FIFO_DEPTH, 1024, readout FIFO depth in words.

Ports:
- clk100  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous active-low reset.
- trig  in  1  scintillator coincidence, already synchronous to clk100. Only its rising edge is used.
- tube_data  in  N_CH*8  captured time per channel; channel k is bits [8k+7:8k].
- fifo_full  in  1  FIFO full flag.
- fifo_wr_count  in  10  FIFO write-side occupancy.
- acq_active  out  1  high during the acquisition window; gates the tube clock.
- tube_clr  out  1  clear to all tube channels.
- tube_cnt  out  8  global time counter to the tubes.
- fifo_din  out  16  FIFO write data.
- fifo_wr_en  out  1  FIFO write strobe.
- busy  out  1  high in any state except IDLE.
- event_cnt  out  16  number of events written.
- drop_cnt  out  16  number of events dropped.

Behaviour:
- Reset values: all outputs 0 except tube_cnt=1. FSM enters IDLE; trigger edge-detect register cleared.
- FSM states: IDLE, ACQUIRE, CHECK, HEADER, SCAN, TRAILER, DROP, CLEAR.
- IDLE -> ACQUIRE:
  - Transition on a trig rising edge (trig=1 and previous trig=0).
  - On the next cycle: acq_active=1 and tube_cnt=1.
- ACQUIRE:
  - tube_cnt increments by 1 each cycle and saturates at 255.
  - Lasts exactly ACQ_CYCLES cycles, then goes to CHECK with acq_active=0.
- CHECK (1 cycle):
  - If fifo_wr_count > FIFO_DEPTH-(N_CH+2), go to DROP. A partial event is never written.
  - Otherwise go to HEADER.
- HEADER: writes {8'hA5, event_cnt[7:0]}.
- SCAN:
  - Writes {tube_data[ch], TAG(ch)} for ch = 0..N_CH-1 in ascending order, where TAG(ch) = {3'b101, ch[4:0]}.
  - The channel mux and fifo_din are registered; fifo_din and fifo_wr_en change together.
- TRAILER: writes 16'hFFFF and increments event_cnt (wraps at 16'hFFFF -> 0).
- Backpressure (HEADER, SCAN, TRAILER):
  - A word is written only when fifo_full=0.
  - While fifo_full=1: fifo_wr_en=0, and the channel index and state hold.
  - No word is ever duplicated or skipped.
- Throughput: an unstalled event is ACQ_CYCLES + 1 + (N_CH+2) + CLR_CYCLES cycles from trigger edge+1 to IDLE.
- DROP: increments drop_cnt (saturates at 16'hFFFF), then goes to CLEAR.
- CLEAR:
  - tube_clr=1 for exactly CLR_CYCLES cycles; tube_cnt is forced to 1.
  - Then returns to IDLE and deasserts tube_clr.
- Trigger handling:
  - Triggers outside IDLE are ignored and not queued.
  - A trig held high across the return to IDLE does not retrigger; a new rising edge is required.
- Asynchronous reset mid-event: the FSM aborts to IDLE immediately, no FIFO write occurs after reset, and the counters clear.
- busy = (state != IDLE).

Decomposition:
- Shared package event_pkg:
  - FSM state enum.
  - HEADER_MAGIC = 8'hA5.
  - TRAILER_WORD = 16'hFFFF.
  - TAG_PREFIX = 3'b101.
  - WORDS_PER_EVENT = N_CH+2.
- Sub-module channel_mux: registered N_CH:1 8-bit selector of tube_data by channel index. It is the only natural split.

Test Plan:
- Single trig pulse with tube_data[k] = k+16 and FIFO empty:
  - acq_active high for 256 cycles.
  - tube_cnt runs 1..255 and saturates.
  - 34 writes: 16'hA500, then 16'h10A0 .. 16'h2FBF, then 16'hFFFF.
  - event_cnt=1, then tube_clr high for 11 cycles.
- fifo_full asserted for 5 cycles in the middle of SCAN at ch=10:
  - fifo_wr_en=0 during the stall.
  - Resumes with ch=10; 34 total words in order, none duplicated.
- fifo_wr_count=1000 at CHECK:
  - Zero writes, drop_cnt=1, event_cnt unchanged, CLEAR still pulses for 11 cycles.
- trig pulses during ACQUIRE and SCAN, plus trig held high through the return to IDLE:
  - Only one event is recorded.
  - The next event starts only on a fresh rising edge.
- rst_n low during SCAN at ch=5:
  - Outputs return to reset values asynchronously; no further writes.
  - The next trig produces a complete event with header byte 8'h00.
- 257 back-to-back events:
  - The header low byte wraps from 8'hFF to 8'h00.
  - event_cnt=257.

Source files
------------

// File: rtl/event_pkg.sv
// Shared types and constants for the drift-tube event readout sequencer.
package event_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACQUIRE,
    CHECK,
    HEADER,
    SCAN,
    TRAILER,
    DROP,
    CLEAR
  } state_t;

  localparam logic [7:0]  HEADER_MAGIC    = 8'hA5;
  localparam logic [15:0] TRAILER_WORD    = 16'hFFFF;
  localparam logic [2:0]  TAG_PREFIX      = 3'b101;
  localparam int          N_CH_DEFAULT    = 32;
  localparam int          WORDS_PER_EVENT = N_CH_DEFAULT + 2;

  // Header + one word per channel + trailer.
  function automatic int words_per_event(input int n_ch);
    return n_ch + 2;
  endfunction

  // Low byte of a channel word: fixed prefix plus the channel number.
  function automatic logic [7:0] chan_tag(input logic [4:0] ch);
    return {TAG_PREFIX, ch};
  endfunction

endpackage

// File: rtl/channel_mux.sv
// Registered N_CH:1 byte selector over the packed tube time-capture bus.
module channel_mux #(
  parameter int N_CH = 32,
  parameter int CH_W = 5
) (
  input  logic              clk100,
  input  logic              rst_n,
  input  logic [N_CH*8-1:0] tube_data,
  input  logic [CH_W-1:0]   sel,
  output logic [7:0]        data_q
);

  // Capture the selected channel byte; the caller selects one cycle ahead.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, and the reset sits in the sensitivity list so
  // it takes effect without a clock.
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= tube_data[{sel, 3'b000} +: 8];
  end

endmodule

// File: rtl/event_readout_sequencer.sv
// Event sequencer: trigger -> acquisition window -> FIFO readout of all tube
// channels (with backpressure and overflow drop) -> tube front-end clear.
module event_readout_sequencer
  import event_pkg::*;
#(
  parameter int N_CH       = 32,
  parameter int ACQ_CYCLES = 256,
  parameter int CLR_CYCLES = 11,
  parameter int FIFO_DEPTH = 1024
) (
  input  logic              clk100,
  input  logic              rst_n,
  input  logic              trig,
  input  logic [N_CH*8-1:0] tube_data,
  input  logic              fifo_full,
  input  logic [9:0]        fifo_wr_count,
  output logic              acq_active,
  output logic              tube_clr,
  output logic [7:0]        tube_cnt,
  output logic [15:0]       fifo_din,
  output logic              fifo_wr_en,
  output logic              busy,
  output logic [15:0]       event_cnt,
  output logic [15:0]       drop_cnt
);

  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int ACQ_W = (ACQ_CYCLES > 1) ? $clog2(ACQ_CYCLES) : 1;
  localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

  localparam logic [CH_W-1:0]  CH_LAST    = CH_W'(N_CH - 1);
  localparam logic [ACQ_W-1:0] ACQ_LAST   = ACQ_W'(ACQ_CYCLES - 1);
  localparam logic [CLR_W-1:0] CLR_LAST   = CLR_W'(CLR_CYCLES - 1);
  // Above this occupancy a whole event no longer fits, so it is dropped.
  localparam logic [9:0]       DROP_LEVEL = 10'(FIFO_DEPTH - words_per_event(N_CH));

  state_t           state;
  logic             trig_q;
  logic [CH_W-1:0]  ch;
  logic [CH_W-1:0]  ch_sel;
  logic [ACQ_W-1:0] acq_cnt;
  logic [CLR_W-1:0] clr_cnt;
  logic [7:0]       mux_q;

  // Point the mux at the channel that will be current next cycle, so its
  // registered output lines up with ch when the word is written.
  // NOTE: the default assignment first means every path drives ch_sel and
  // no latch is inferred.
  always_comb begin
    ch_sel = ch;
    if (state == SCAN && !fifo_full) ch_sel = ch + CH_W'(1);
  end

  channel_mux #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_channel_mux (
    .clk100    (clk100),
    .rst_n     (rst_n),
    .tube_data (tube_data),
    .sel       (ch_sel),
    .data_q    (mux_q)
  );

  assign busy = (state != IDLE);

  // Main sequencer FSM with registered outputs and counters.
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      trig_q     <= 1'b0;
      ch         <= '0;
      acq_cnt    <= '0;
      clr_cnt    <= '0;
      acq_active <= 1'b0;
      tube_clr   <= 1'b0;
      tube_cnt   <= 8'd1;
      fifo_din   <= '0;
      fifo_wr_en <= 1'b0;
      event_cnt  <= '0;
      drop_cnt   <= '0;
    end else begin
      // Tracked in every state so a trig held high never looks like a new edge.
      trig_q     <= trig;
      fifo_wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (trig && !trig_q) begin
            state      <= ACQUIRE;
            acq_active <= 1'b1;
            tube_cnt   <= 8'd1;
            acq_cnt    <= '0;
          end
        end
        ACQUIRE: begin
          if (tube_cnt != 8'hFF) tube_cnt <= tube_cnt + 8'd1;
          if (acq_cnt == ACQ_LAST) begin
            state      <= CHECK;
            acq_active <= 1'b0;
          end else begin
            acq_cnt <= acq_cnt + ACQ_W'(1);
          end
        end
        CHECK: begin
          ch    <= '0;
          state <= (fifo_wr_count > DROP_LEVEL) ? DROP : HEADER;
        end
        HEADER: begin
          if (!fifo_full) begin
            fifo_din   <= {HEADER_MAGIC, event_cnt[7:0]};
            fifo_wr_en <= 1'b1;
            state      <= SCAN;
          end
        end
        SCAN: begin
          if (!fifo_full) begin
            fifo_din   <= {mux_q, chan_tag(5'(ch))};
            fifo_wr_en <= 1'b1;
            ch         <= ch + CH_W'(1);
            if (ch == CH_LAST) state <= TRAILER;
          end
        end
        TRAILER: begin
          if (!fifo_full) begin
            fifo_din   <= TRAILER_WORD;
            fifo_wr_en <= 1'b1;
            event_cnt  <= event_cnt + 16'd1;
            state      <= CLEAR;
            tube_clr   <= 1'b1;
            tube_cnt   <= 8'd1;
            clr_cnt    <= '0;
          end
        end
        DROP: begin
          if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
          state    <= CLEAR;
          tube_clr <= 1'b1;
          tube_cnt <= 8'd1;
          clr_cnt  <= '0;
        end
        CLEAR: begin
          tube_cnt <= 8'd1;
          if (clr_cnt == CLR_LAST) begin
            state    <= IDLE;
            tube_clr <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt + CLR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_event_readout_sequencer.sv
// Self-checking bench: table of whole-event scenarios plus hand-written
// reset-abort and counter-wrap sequences; FIFO words go through a scoreboard.
module tb_event_readout_sequencer;

  logic          clk100 = 1'b0;
  logic          rst_n;
  logic          trig;
  logic [255:0]  tube_data;
  logic          fifo_full;
  logic [9:0]    fifo_wr_count;
  logic          acq_active;
  logic          tube_clr;
  logic [7:0]    tube_cnt;
  logic [15:0]   fifo_din;
  logic          fifo_wr_en;
  logic          busy;
  logic [15:0]   event_cnt;
  logic [15:0]   drop_cnt;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [15:0]   exp_q[$];
  logic [15:0]   exp_w;
  logic [15:0]   model_evt = '0;
  logic [15:0]   model_drop = '0;

  typedef struct {
    logic [9:0]  wr_count;
    int          stall_word;  // stall while deciding this word index (-1: none)
    int          stall_len;
    int          pulse_a;     // extra one-cycle trig pulses, cycle index (-1: none)
    int          pulse_b;
    int          hold_from;   // raise trig and keep it high from this cycle (-1: none)
    int          mul;         // tube byte k = k*mul + add
    int          add;
    logic [15:0] exp_event;
    logic [15:0] exp_drop;
    int          exp_words;
    int          exp_cycles;
  } vec_t;

  vec_t tbl[8];

  event_readout_sequencer dut (
    .clk100        (clk100),
    .rst_n         (rst_n),
    .trig          (trig),
    .tube_data     (tube_data),
    .fifo_full     (fifo_full),
    .fifo_wr_count (fifo_wr_count),
    .acq_active    (acq_active),
    .tube_clr      (tube_clr),
    .tube_cnt      (tube_cnt),
    .fifo_din      (fifo_din),
    .fifo_wr_en    (fifo_wr_en),
    .busy          (busy),
    .event_cnt     (event_cnt),
    .drop_cnt      (drop_cnt)
  );

  always #5 clk100 = ~clk100;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int k, input int mul, input int add);
    return 8'(k * mul + add);
  endfunction

  // Scoreboard: every observed FIFO write must match the next expected word.
  always @(negedge clk100) begin
    if (fifo_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got %0h, required no write", fifo_din);
      end else begin
        exp_w = exp_q.pop_front();
        check("fifo_din", 32'(fifo_din), 32'(exp_w));
      end
    end
  end

  task automatic load_pattern(input int mul, input int add);
    for (int k = 0; k < 32; k++) tube_data[8*k +: 8] = pat(k, mul, add);
  endtask

  task automatic push_words(input int n, input int mul, input int add);
    exp_q.push_back({8'hA5, model_evt[7:0]});
    for (int k = 0; k < 32 && k + 1 < n; k++)
      exp_q.push_back({pat(k, mul, add), 3'b101, 5'(k)});
    if (n == 34) exp_q.push_back(16'hFFFF);
  endtask

  task automatic check_reset_values();
    check("rst_acq_active", 32'(acq_active), 32'd0);
    check("rst_tube_clr",   32'(tube_clr),   32'd0);
    check("rst_tube_cnt",   32'(tube_cnt),   32'd1);
    check("rst_fifo_din",   32'(fifo_din),   32'd0);
    check("rst_fifo_wr_en", 32'(fifo_wr_en), 32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_event_cnt",  32'(event_cnt),  32'd0);
    check("rst_drop_cnt",   32'(drop_cnt),   32'd0);
  endtask

  task automatic run_event(input vec_t v);
    bit drop;
    int cyc, acq_n, clr_n, wr_n, cnt_bad, stall_left, exp_cnt, busy_n;
    drop = (v.wr_count > 10'd990);
    fifo_wr_count = v.wr_count;
    load_pattern(v.mul, v.add);
    if (!drop) push_words(34, v.mul, v.add);
    @(negedge clk100);
    trig = 1'b1;
    @(negedge clk100);
    trig = 1'b0;
    cyc = 0; acq_n = 0; clr_n = 0; wr_n = 0; cnt_bad = 0; stall_left = 0;
    while (busy === 1'b1 && cyc < 2000) begin
      if (stall_left > 0) begin
        check("stall_wr_en", 32'(fifo_wr_en), 32'd0);
        stall_left--;
        if (stall_left == 0) fifo_full = 1'b0;
      end
      if (fifo_wr_en === 1'b1) begin
        wr_n++;
        if (wr_n == v.stall_word) begin
          fifo_full  = 1'b1;
          stall_left = v.stall_len;
        end
      end
      if (acq_active === 1'b1) begin
        acq_n++;
        exp_cnt = (cyc + 1 > 255) ? 255 : cyc + 1;
        if (tube_cnt !== 8'(exp_cnt)) cnt_bad++;
      end
      if (tube_clr === 1'b1) begin
        clr_n++;
        if (tube_cnt !== 8'd1) cnt_bad++;
      end
      trig = (cyc == v.pulse_a) || (cyc == v.pulse_b) ||
             (v.hold_from >= 0 && cyc >= v.hold_from);
      @(negedge clk100);
      cyc++;
    end
    check("event_cycles", 32'(cyc),     32'(v.exp_cycles));
    check("acq_len",      32'(acq_n),   32'd256);
    check("clr_len",      32'(clr_n),   32'd11);
    check("tube_cnt_seq", 32'(cnt_bad), 32'd0);
    check("word_count",   32'(wr_n),    32'(v.exp_words));
    check("event_cnt",    32'(event_cnt), 32'(v.exp_event));
    check("drop_cnt",     32'(drop_cnt),  32'(v.exp_drop));
    check("idle_tube_cnt", 32'(tube_cnt), 32'd1);
    if (drop) model_drop++;
    else      model_evt++;
    if (v.hold_from >= 0) begin
      busy_n = 0;
      repeat (20) begin
        @(negedge clk100);
        if (busy !== 1'b0) busy_n++;
      end
      check("no_retrigger", 32'(busy_n), 32'd0);
      trig = 1'b0;
    end
    fifo_wr_count = '0;
    fifo_full     = 1'b0;
  endtask

  initial begin
    int   n, cyc;
    vec_t w;

    //          wr_cnt  stw len  pa   pb   hold mul add  evt     drop   words cyc
    tbl[0] = '{10'd0,   -1, 0,  -1,  -1,  -1,  1,  16, 16'd1, 16'd0, 34, 302};
    tbl[1] = '{10'd0,   11, 5,  -1,  -1,  -1,  3,  7,  16'd2, 16'd0, 34, 307};
    tbl[2] = '{10'd1000,-1, 0,  -1,  -1,  -1,  1,  0,  16'd2, 16'd1, 0,  269};
    tbl[3] = '{10'd990, -1, 0,  -1,  -1,  -1,  7,  1,  16'd3, 16'd1, 34, 302};
    tbl[4] = '{10'd991, -1, 0,  -1,  -1,  -1,  1,  0,  16'd3, 16'd2, 0,  269};
    tbl[5] = '{10'd500, 33, 2,  -1,  -1,  -1,  5,  200, 16'd4, 16'd2, 34, 304};
    tbl[6] = '{10'd0,   -1, 0,  50,  270, 295, 9,  33, 16'd5, 16'd2, 34, 302};
    tbl[7] = '{10'd0,   -1, 0,  -1,  -1,  -1,  2,  128, 16'd6, 16'd2, 34, 302};

    rst_n = 1'b1;
    trig = 1'b0;
    fifo_full = 1'b0;
    fifo_wr_count = '0;
    tube_data = '0;
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk100);
    check_reset_values();
    rst_n = 1'b1;
    repeat (2) @(negedge clk100);

    for (int i = 0; i < 8; i++) run_event(tbl[i]);

    // Asynchronous reset while the sequencer is in SCAN at channel 5.
    load_pattern(1, 16);
    push_words(6, 1, 16);
    @(negedge clk100);
    trig = 1'b1;
    @(negedge clk100);
    trig = 1'b0;
    n = 0;
    cyc = 0;
    while (n < 6 && cyc < 400) begin
      if (fifo_wr_en === 1'b1) n++;
      if (n < 6) begin
        @(negedge clk100);
        cyc++;
      end
    end
    check("reset_at_ch5", 32'(n), 32'd6);
    #2 rst_n = 1'b0;
    #1 check_reset_values();
    repeat (3) @(negedge clk100);
    check("reset_no_write", 32'(fifo_wr_en), 32'd0);
    rst_n = 1'b1;
    model_evt  = '0;
    model_drop = '0;

    // Back-to-back events from a cleared counter: header byte wraps 8'hFF -> 8'h00.
    for (int i = 0; i < 257; i++) begin
      w = '{10'd0, -1, 0, -1, -1, -1, 1, i, 16'(i + 1), 16'd0, 34, 302};
      run_event(w);
    end
    check("event_cnt_wrap", 32'(event_cnt), 32'd257);

    repeat (2) @(negedge clk100);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
